// File: rtl/mem_stage_ctrl.sv
// Multi-cycle data-memory stage: word-addressed array with fixed access latency,
// pipeline stall generation, illegal-request rejection and an absorbing halt state.
module mem_stage_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 256,
    parameter int LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic                  halt,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  Stall,
    output logic                  Done,
    output logic                  Err,
    output logic                  Halted
);

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BUSY   = 2'd1,
        S_DONE   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_next;
    logic                  r_op_wr;
    logic                  r_err;
    logic [IW-1:0]         r_idx;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic w_req;
    logic w_illegal;
    logic w_accept;
    logic w_reject;
    logic w_commit;

    assign w_req     = MemRead | MemWrite;
    // Index range is checked on the full address so aliasing above DEPTH is rejected.
    assign w_illegal = (MemRead & MemWrite) | Address[0] |
                       ({1'b0, Address[ADDR_WIDTH-1:1]} >= ADDR_WIDTH'(DEPTH));
    assign w_accept  = (r_state == S_IDLE) & w_req & ~w_illegal;
    assign w_reject  = (r_state == S_IDLE) & w_req & w_illegal;
    assign w_commit  = (r_state == S_BUSY) & (r_cnt == {CW{1'b0}});

    assign ReadData = r_rdata;
    assign Done     = (r_state == S_DONE);
    assign Err      = (r_state == S_DONE) & r_err;
    assign Halted   = (r_state == S_HALTED);

    // State, latency counter, latched request and load result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= {CW{1'b0}};
            r_op_wr <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= {IW{1'b0}};
            r_wdata <= {DATA_WIDTH{1'b0}};
            r_rdata <= {DATA_WIDTH{1'b0}};
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_op_wr <= MemWrite;
                r_idx   <= Address[IW:1];
                r_wdata <= WriteData;
                r_err   <= 1'b0;
            end else if (w_reject) begin
                r_err   <= 1'b1;
            end
            if (w_commit && !r_op_wr) begin
                r_rdata <= r_mem[r_idx];
            end
        end
    end

    // Array storage; not cleared by reset, and reset forces IDLE so no commit occurs.
    always_ff @(posedge clk) begin
        if (w_commit && r_op_wr) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    // Next-state, counter and stall decode.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        Stall      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    Stall = 1'b1;
                    if (w_illegal) begin
                        w_next = S_DONE;
                    end else begin
                        w_next     = S_BUSY;
                        w_cnt_next = CW'(LATENCY - 1);
                    end
                end else if (halt) begin
                    w_next = S_HALTED;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_BUSY: begin
                Stall = 1'b1;
                if (r_cnt != {CW{1'b0}}) begin
                    w_cnt_next = r_cnt - CW'(1);
                end else begin
                    w_next = S_DONE;
                end
            end
            S_DONE:   w_next = S_IDLE;
            S_HALTED: w_next = S_HALTED;
            default:  w_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: a LATENCY=4 instance and a LATENCY=1 instance share stimulus.
module tb_mem_stage_ctrl;

    logic        clk;
    logic        rst;
    logic        MemRead;
    logic        MemWrite;
    logic        halt;
    logic [15:0] Address;
    logic [15:0] WriteData;

    logic [15:0] rd4, rd1;
    logic        st4, st1, dn4, dn1, er4, er1, hl4, hl1;
    logic        sel;

    logic [15:0] o_rd;
    logic        o_stall, o_done, o_err, o_halted;

    int n_checks;
    int n_errors;

    mem_stage_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH(256), .LATENCY(4)) u_dut (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .halt(halt),
        .Address(Address), .WriteData(WriteData), .ReadData(rd4), .Stall(st4),
        .Done(dn4), .Err(er4), .Halted(hl4)
    );

    mem_stage_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH(256), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .halt(halt),
        .Address(Address), .WriteData(WriteData), .ReadData(rd1), .Stall(st1),
        .Done(dn1), .Err(er1), .Halted(hl1)
    );

    assign o_rd     = sel ? rd1 : rd4;
    assign o_stall  = sel ? st1 : st4;
    assign o_done   = sel ? dn1 : dn4;
    assign o_err    = sel ? er1 : er4;
    assign o_halted = sel ? hl1 : hl4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; returns stalled-cycle count and the cycle Done appeared (-1 if never).
    task automatic access(input logic rd, input logic wr, input logic [15:0] addr,
                          input logic [15:0] wd, output int stalls, output int done_cyc,
                          output logic err);
        MemRead   = rd;
        MemWrite  = wr;
        Address   = addr;
        WriteData = wd;
        stalls    = 0;
        done_cyc  = -1;
        err       = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (o_stall) stalls++;
            if (o_done) begin
                done_cyc = c;
                err      = o_err;
                break;
            end
        end
        @(posedge clk);
        #1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    int   s, d;
    logic e;

    initial begin
        n_checks = 0; n_errors = 0; sel = 1'b0;
        MemRead = 1'b0; MemWrite = 1'b0; halt = 1'b0; Address = 16'h0; WriteData = 16'h0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_done", {31'd0, o_done}, 32'd0);
        check("rst_err", {31'd0, o_err}, 32'd0);
        check("rst_halted", {31'd0, o_halted}, 32'd0);
        check("rst_rdata", {16'd0, o_rd}, 32'd0);
        check("rst_stall", {31'd0, o_stall}, 32'd0);
        @(posedge clk); #1; rst = 1'b0;

        access(1'b0, 1'b1, 16'h0010, 16'hBEEF, s, d, e);
        check("wr_stalls", s, 32'd5);
        check("wr_done_cyc", d, 32'd5);
        check("wr_err", {31'd0, e}, 32'd0);
        access(1'b1, 1'b0, 16'h0010, 16'h0000, s, d, e);
        check("rd_stalls", s, 32'd5);
        check("rd_done_cyc", d, 32'd5);
        check("rd_data", {16'd0, o_rd}, 32'h0000BEEF);

        access(1'b1, 1'b0, 16'h0011, 16'h0000, s, d, e);
        check("odd_stalls", s, 32'd1);
        check("odd_done_cyc", d, 32'd1);
        check("odd_err", {31'd0, e}, 32'd1);
        check("odd_rdata_kept", {16'd0, o_rd}, 32'h0000BEEF);
        access(1'b1, 1'b1, 16'h0010, 16'h1111, s, d, e);
        check("rdwr_done_cyc", d, 32'd1);
        check("rdwr_err", {31'd0, e}, 32'd1);
        access(1'b1, 1'b0, 16'h0200, 16'h0000, s, d, e);
        check("oob_err", {31'd0, e}, 32'd1);
        check("oob_done_cyc", d, 32'd1);
        access(1'b0, 1'b1, 16'h01FE, 16'hCAFE, s, d, e);
        check("top_wr_err", {31'd0, e}, 32'd0);
        access(1'b1, 1'b0, 16'h01FE, 16'h0000, s, d, e);
        check("top_rd_err", {31'd0, e}, 32'd0);
        check("top_rd_data", {16'd0, o_rd}, 32'h0000CAFE);
        access(1'b1, 1'b0, 16'h0010, 16'h0000, s, d, e);
        check("bb_rd_data", {16'd0, o_rd}, 32'h0000BEEF);

        // Reset in the middle of a write must leave the array untouched.
        access(1'b0, 1'b1, 16'h0020, 16'h5A5A, s, d, e);
        MemWrite = 1'b1; Address = 16'h0020; WriteData = 16'h1234;
        repeat (2) @(posedge clk);
        #2;
        check("mid_stall_busy", {31'd0, o_stall}, 32'd1);
        rst = 1'b1; MemWrite = 1'b0;
        #1;
        check("mid_rst_rdata", {16'd0, o_rd}, 32'd0);
        check("mid_rst_stall", {31'd0, o_stall}, 32'd0);
        check("mid_rst_done", {31'd0, o_done}, 32'd0);
        check("mid_rst_halted", {31'd0, o_halted}, 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        access(1'b1, 1'b0, 16'h0020, 16'h0000, s, d, e);
        check("mid_rst_mem", {16'd0, o_rd}, 32'h00005A5A);

        halt = 1'b1;
        @(negedge clk);
        check("halt_cyc0", {31'd0, o_halted}, 32'd0);
        @(negedge clk);
        check("halt_cyc1", {31'd0, o_halted}, 32'd1);
        @(posedge clk); #1;
        access(1'b1, 1'b0, 16'h0020, 16'h0000, s, d, e);
        check("halt_no_stall", s, 32'd0);
        check("halt_no_done", d, 32'hFFFFFFFF);
        check("halt_sticky", {31'd0, o_halted}, 32'd1);

        halt = 1'b0;
        do_reset();
        halt = 1'b1;
        access(1'b1, 1'b0, 16'h0010, 16'h0000, s, d, e);
        check("halt_rd_done_cyc", d, 32'd5);
        check("halt_rd_data", {16'd0, o_rd}, 32'h0000BEEF);
        @(negedge clk);
        check("halt_after_done1", {31'd0, o_halted}, 32'd0);
        @(negedge clk);
        check("halt_after_done2", {31'd0, o_halted}, 32'd1);
        halt = 1'b0;

        do_reset();
        sel = 1'b1;
        for (int k = 0; k < 8; k++) begin
            access(1'b0, 1'b1, 16'h0040 + 16'(2 * k), 16'hA000 + 16'(k * 17), s, d, e);
            check($sformatf("l1_wr_stalls%0d", k), s, 32'd2);
            check($sformatf("l1_wr_done%0d", k), d, 32'd2);
        end
        for (int k = 0; k < 8; k++) begin
            access(1'b1, 1'b0, 16'h0040 + 16'(2 * k), 16'h0000, s, d, e);
            check($sformatf("l1_rd_stalls%0d", k), s, 32'd2);
            check($sformatf("l1_rd_data%0d", k), {16'd0, o_rd}, {16'd0, 16'hA000 + 16'(k * 17)});
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
